// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  // Fetch side
  logic                      if_req;
  logic [ADDRESS_WIDTH-1:0]  if_addr;
  logic                      if_flush;
  logic [DATA_WIDTH-1:0]     if_rdata;
  logic                      if_valid;
  logic                      if_stall;

  // Data side
  logic                      dm_req;
  logic                      dm_we;
  logic [ADDRESS_WIDTH-1:0]  dm_addr;
  logic [DATA_WIDTH-1:0]     dm_wdata;
  logic [DATA_WIDTH/8-1:0]   dm_wstrb;
  logic [DATA_WIDTH-1:0]     dm_rdata;
  logic                      dm_valid;
  logic                      dm_stall;

  // Memory side
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, one transaction at a time.
// Data wins over fetch until a fetch has waited out STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StDReq,
    StDResp,
    StFReq,
    StFResp
  } state_e;

  state_e                   state_q;
  logic                     drop_q;
  logic [CntW-1:0]          starve_q;
  logic                     mem_req_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [StrbW-1:0]         mem_wstrb_q;

  logic grant_dm;
  logic grant_if;
  logic if_valid;
  logic dm_valid;

  always_comb begin
    grant_dm = bus.dm_req && ((starve_q < StarveMax) || !bus.if_req);
    grant_if = !grant_dm && bus.if_req && !bus.if_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          drop_q <= 1'b0;
          if (grant_dm) begin
            state_q     <= StDReq;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_wstrb_q <= bus.dm_wstrb;
            // Only grants that make a waiting fetch wait longer count toward starvation.
            if (!bus.if_req) begin
              starve_q <= '0;
            end else if (starve_q != StarveMax) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (grant_if) begin
            state_q     <= StFReq;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wstrb_q <= '0;
            starve_q    <= '0;
          end else if (!bus.if_req) begin
            starve_q <= '0;
          end
        end
        StDReq: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StDResp;
          end
        end
        StDResp: begin
          if (bus.mem_rvalid) begin
            state_q <= StIdle;
          end
        end
        StFReq: begin
          if (bus.if_flush) begin
            drop_q <= 1'b1;
          end
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StFResp;
          end
        end
        StFResp: begin
          if (bus.mem_rvalid) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
          end else if (bus.if_flush) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush coinciding with the response also kills it, hence the live if_flush term.
  always_comb begin
    dm_valid = (state_q == StDResp) && bus.mem_rvalid;
    if_valid = (state_q == StFResp) && bus.mem_rvalid && !drop_q && !bus.if_flush;
  end

  assign bus.dm_valid  = dm_valid;
  assign bus.dm_rdata  = dm_valid ? bus.mem_rdata : '0;
  assign bus.dm_stall  = bus.dm_req && !dm_valid;
  assign bus.if_valid  = if_valid;
  assign bus.if_rdata  = if_valid ? bus.mem_rdata : '0;
  assign bus.if_stall  = bus.if_req && !if_valid;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, contention, fetch flush, store wait states, reset.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_flush   = 1'b0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_wstrb   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Reset values
    step(); step();
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_dm_valid", bus.dm_valid, 0);
    step();
    rst_n = 1'b1;

    // Single zero-wait load
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
    #1;
    chk("ld_c0_stall", bus.dm_stall, 1);
    chk("ld_c0_req", bus.mem_req, 0);
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("ld_c1_req", bus.mem_req, 1);
    chk("ld_c1_addr", bus.mem_addr, 32'h100);
    chk("ld_c1_we", bus.mem_we, 0);
    chk("ld_c1_stall", bus.dm_stall, 1);
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_c2_req", bus.mem_req, 0);
    chk("ld_c2_valid", bus.dm_valid, 1);
    chk("ld_c2_rdata", bus.dm_rdata, 32'hDEADBEEF);
    chk("ld_c2_stall", bus.dm_stall, 0);
    step();
    bus.dm_req = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    chk("ld_c3_valid", bus.dm_valid, 0);
    chk("ld_c3_rdata", bus.dm_rdata, 0);
    step();
    #1;
    chk("ld_c4_req", bus.mem_req, 0);

    // Contention: four data grants, one fetch, four data, one fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2000; bus.dm_we = 1'b0;
    for (int t = 0; t < 10; t++) begin
      logic is_f;
      is_f = (t == 4) || (t == 9);
      #1;
      chk("cont_idle_req", bus.mem_req, 0);
      step();
      bus.mem_gnt = 1'b1;
      #1;
      chk("cont_req", bus.mem_req, 1);
      chk("cont_addr", bus.mem_addr, is_f ? 32'h1000 : 32'h2000);
      step();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5000 + t;
      #1;
      chk("cont_if_valid", bus.if_valid, is_f);
      chk("cont_dm_valid", bus.dm_valid, !is_f);
      chk("cont_if_stall", bus.if_stall, !is_f);
      chk("cont_dm_stall", bus.dm_stall, is_f);
      if (is_f) chk("cont_if_rdata", bus.if_rdata, 32'h5000 + t);
      else      chk("cont_dm_rdata", bus.dm_rdata, 32'h5000 + t);
      step();
      bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    #1;
    chk("cont_end_req", bus.mem_req, 0);

    // Flush in IDLE suppresses the issue
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    #1;
    chk("fl_idle_noissue", bus.mem_req, 0);
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("fl_req", bus.mem_req, 1);
    chk("fl_addr", bus.mem_addr, 32'h40);
    chk("fl_we", bus.mem_we, 0);
    chk("fl_wstrb", bus.mem_wstrb, 0);
    // Flush pulsed in F_RESP, response arrives three cycles later
    step();
    bus.mem_gnt = 1'b0; bus.if_flush = 1'b1;
    #1;
    chk("fl_resp_valid", bus.if_valid, 0);
    step();
    bus.if_flush = 1'b0; bus.if_addr = 32'h80;
    step();
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    #1;
    chk("fl_drop_valid", bus.if_valid, 0);
    chk("fl_drop_rdata", bus.if_rdata, 0);
    chk("fl_drop_stall", bus.if_stall, 1);
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("fl_idle_req", bus.mem_req, 0);
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("fl_new_req", bus.mem_req, 1);
    chk("fl_new_addr", bus.mem_addr, 32'h80);
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE0080;
    #1;
    chk("fl_new_valid", bus.if_valid, 1);
    chk("fl_new_rdata", bus.if_rdata, 32'hCAFE0080);
    // Flush coinciding with the response
    step();
    bus.mem_rvalid = 1'b0; bus.if_addr = 32'hC0;
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("fl_same_addr", bus.mem_addr, 32'hC0);
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h777; bus.if_flush = 1'b1;
    #1;
    chk("fl_same_valid", bus.if_valid, 0);
    chk("fl_same_rdata", bus.if_rdata, 0);
    step();
    bus.mem_rvalid = 1'b0; bus.if_flush = 1'b0; bus.if_req = 1'b0;

    // Store with two grant wait states; fields scrambled after issue
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h300;
    bus.dm_wdata = 32'hA5A50F0F; bus.dm_wstrb = 4'b0011;
    for (int w = 0; w < 3; w++) begin
      step();
      bus.dm_addr = 32'hFFFC; bus.dm_wdata = 32'h0; bus.dm_wstrb = 4'hF; bus.dm_we = 1'b0;
      bus.mem_gnt = (w == 2);
      #1;
      chk("st_req", bus.mem_req, 1);
      chk("st_we", bus.mem_we, 1);
      chk("st_addr", bus.mem_addr, 32'h300);
      chk("st_wdata", bus.mem_wdata, 32'hA5A50F0F);
      chk("st_wstrb", bus.mem_wstrb, 4'b0011);
      chk("st_stall", bus.dm_stall, 1);
    end
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
    #1;
    chk("st_ack_valid", bus.dm_valid, 1);
    chk("st_ack_stall", bus.dm_stall, 0);
    chk("st_ack_req", bus.mem_req, 0);
    step();
    bus.mem_rvalid = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;

    // Reset during D_RESP
    step();
    bus.dm_req = 1'b1; bus.dm_addr = 32'h400;
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("rm_req", bus.mem_req, 1);
    step();
    bus.mem_gnt = 1'b0; bus.dm_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("rm_abort_req", bus.mem_req, 0);
    chk("rm_abort_addr", bus.mem_addr, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD;
    #1;
    chk("rm_spur_dm_valid", bus.dm_valid, 0);
    chk("rm_spur_if_valid", bus.if_valid, 0);
    chk("rm_spur_rdata", bus.dm_rdata, 0);
    step();
    bus.mem_rvalid = 1'b0; bus.dm_req = 1'b1; bus.dm_addr = 32'h404;
    step();
    bus.mem_gnt = 1'b1;
    #1;
    chk("rm_after_req", bus.mem_req, 1);
    chk("rm_after_addr", bus.mem_addr, 32'h404);
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11;
    #1;
    chk("rm_after_valid", bus.dm_valid, 1);
    chk("rm_after_rdata", bus.dm_rdata, 32'h11);
    step();
    bus.mem_rvalid = 1'b0; bus.dm_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
